// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin CPU/debug arbiter for a single-port word memory with
//            sub-word load extraction and read-modify-write sub-word stores.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_signed,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [31:0]       cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [1:0]        dbg_size,
    input  logic              dbg_signed,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_done,
    output logic              dbg_err,
    output logic [31:0]       dbg_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q,  state_d;
    logic              owner_q,  owner_d;   // 0 = cpu, 1 = dbg
    logic              last_q,   last_d;    // last served port
    logic              we_q,     we_d;
    logic [1:0]        size_q,   size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [15:0]       wdata_q,  wdata_d;
    logic              err_q,    err_d;
    logic [31:0]       data_q,   data_d;

    logic              w_grant_cpu;
    logic              w_grant_dbg;
    logic              w_req_we;
    logic [1:0]        w_req_size;
    logic              w_req_signed;
    logic [ADDR_W-1:0] w_req_addr;
    logic [31:0]       w_req_wdata;
    logic              w_misalign;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_extracted;
    logic [31:0]       w_merged;
    logic              w_done;
    logic              w_rdata_ok;

    // CPU wins unless dbg also requests and the CPU was served last.
    assign w_grant_cpu  = cpu_req && (!dbg_req || last_q);
    assign w_grant_dbg  = dbg_req && !w_grant_cpu;
    assign w_req_we     = w_grant_dbg ? dbg_we     : cpu_we;
    assign w_req_size   = w_grant_dbg ? dbg_size   : cpu_size;
    assign w_req_signed = w_grant_dbg ? dbg_signed : cpu_signed;
    assign w_req_addr   = w_grant_dbg ? dbg_addr   : cpu_addr;
    assign w_req_wdata  = w_grant_dbg ? dbg_wdata  : cpu_wdata;
    assign w_misalign   = ((w_req_size == 2'b01) && w_req_addr[0]) ||
                          (w_req_size[1] && (w_req_addr[1:0] != 2'b00));

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        w_byte = 8'h00;
        case (addr_q[1:0])
            2'b00:   w_byte = mem_rdata[31:24];
            2'b01:   w_byte = mem_rdata[23:16];
            2'b10:   w_byte = mem_rdata[15:8];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

        w_extracted = mem_rdata;
        case (size_q)
            2'b00:   w_extracted = {{24{signed_q & w_byte[7]}}, w_byte};
            2'b01:   w_extracted = {{16{signed_q & w_half[15]}}, w_half};
            default: w_extracted = mem_rdata;
        endcase

        w_merged = mem_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   w_merged[31:24] = wdata_q[7:0];
                2'b01:   w_merged[23:16] = wdata_q[7:0];
                2'b10:   w_merged[15:8]  = wdata_q[7:0];
                default: w_merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            w_merged[15:0] = wdata_q;
        end else begin
            w_merged[31:16] = wdata_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (w_grant_cpu || w_grant_dbg) begin
                    owner_d  = w_grant_dbg;
                    we_d     = w_req_we;
                    size_d   = w_req_size;
                    signed_d = w_req_signed;
                    addr_d   = w_req_addr;
                    wdata_d  = w_req_wdata[15:0];
                    err_d    = w_misalign;
                    data_d   = 32'h0;
                    if (w_misalign) begin
                        state_d = S_DONE;
                    end else if (w_req_we && w_req_size[1]) begin
                        data_d  = w_req_wdata;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:   state_d = S_CAP;
            S_CAP: begin
                data_d  = we_q ? w_merged : w_extracted;
                state_d = we_q ? S_WR : S_DONE;
            end
            S_WR:   state_d = S_DONE;
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 16'h0;
            err_q    <= 1'b0;
            data_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

    // Strobes are masked by reset so a reset edge never commits a write.
    assign mem_en    = reset && ((state_q == S_RD) || (state_q == S_WR));
    assign mem_we    = reset && (state_q == S_WR);
    assign mem_addr  = ((state_q == S_RD) || (state_q == S_WR)) ?
                       {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = (state_q == S_WR) ? data_q : 32'h0;

    assign w_done     = (state_q == S_DONE);
    assign w_rdata_ok = w_done && !we_q && !err_q;
    assign cpu_done   = w_done && !owner_q;
    assign dbg_done   = w_done &&  owner_q;
    assign cpu_err    = cpu_done && err_q;
    assign dbg_err    = dbg_done && err_q;
    assign cpu_rdata  = (w_rdata_ok && !owner_q) ? data_q : 32'h0;
    assign dbg_rdata  = (w_rdata_ok &&  owner_q) ? data_q : 32'h0;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port data-memory controller between the single-cycle-derived core's load/store path and the debug/loader port. Owns the single-port word-wide data memory: round-robin arbitration, lb/lbu/lh/lhu/lw extraction with sign/zero extension, and sb/sh stores as read-modify-write sequences. Sits between `top`'s datapath and the data memory macro; memory has 1-cycle synchronous read latency.

## Interface

- ADDR_W, 32, byte-address width on all ports

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low: reset==0 at a rising edge resets the block
- cpu_req  in  1  CPU request, held until cpu_done
- cpu_we  in  1  1 store, 0 load
- cpu_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- cpu_signed  in  1  sign-extend loads (ignored for word/stores)
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  store data, right-justified
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  misaligned, valid with cpu_done
- cpu_rdata  out  32  load result, valid with cpu_done
- dbg_req, dbg_we, dbg_size, dbg_signed, dbg_addr, dbg_wdata, dbg_done, dbg_err, dbg_rdata: identical set for debug port
- mem_en  out  1  memory access strobe
- mem_we  out  1  write strobe (only with mem_en)
- mem_addr  out  ADDR_W  word-aligned address, [1:0]=00
- mem_wdata  out  32  full-word write data
- mem_rdata  in  32  read data, valid cycle after mem_en && !mem_we

## Operation

- FSM states: IDLE, RD, CAP, WR, DONE.
- IDLE: sample requests. If any, grant per round-robin; latch owner, we, size, signed, addr, wdata. Requester inputs may change after grant.
- Round-robin: last-served pointer; on simultaneous requests grant the port not last served. Reset value of pointer = dbg, so CPU wins first tie.
- Alignment check at grant: half with addr[0]=1 or word with addr[1:0]!=00 -> DONE with err=1; no memory access.
- Word store: IDLE -> WR -> DONE.
- Load (any size): IDLE -> RD -> CAP -> DONE. CAP registers extracted result.
- Byte/half store: IDLE -> RD -> CAP (merge lane into read word) -> WR -> DONE.
- DONE: pulse owner's done (and err if set), rdata valid; update pointer; -> IDLE. Non-owner done stays 0.
- Lanes big-endian: byte offset 00 = bits 31:24, 11 = 7:0; half offset 00 = 31:16, 10 = 15:0.
- Extension: signed -> replicate MSB of byte/half to 32 bits; unsigned -> zero fill. Word load ignores signed.
- Merge: only the addressed lane replaced with wdata[7:0] / wdata[15:0]; other lanes unchanged.
- Stores return rdata = 0. Error returns rdata = 0.
- A req still high in the IDLE cycle after DONE is a new transaction.

## Timing

- Grant cycle T (IDLE, req sampled). Done asserted in: error T+1; word store T+2; load T+3; sub-word store T+4.
- mem_en: RD at T+1; WR at T+1 (word store) or T+3 (sub-word store). mem_we=1 only in WR.
- mem_rdata sampled in CAP (T+2).
- Throughput with continuous requests: one transaction per (latency+1) cycles; no overlap.
- Reset (reset==0 at edge), any state: next cycle state IDLE, pointer=dbg, all done/err/mem_en/mem_we=0, all rdata/mem_addr/mem_wdata=0. In-flight RD/CAP of a sub-word store never issues WR; no done pulse for the aborted transaction.
- Reset while WR driven: write occurs only if that edge is not a reset edge; mem_en is 0 the cycle after.

## Test plan

- Memory word 0x50 = 0x12FA5678; CPU lb signed addr 0x51 -> cpu_done at T+3, cpu_rdata 0xFFFFFFFA; lbu same addr -> 0x000000FA; lh signed 0x52 -> 0x00005678.
- Word 0x50 = 0x11223344; CPU sh 0x0000BEEF to 0x52 -> mem_we at T+3, mem_addr 0x50, mem_wdata 0x1122BEEF, done T+4; sb 0xAB to 0x50 -> 0xAB223344.
- CPU sw 0xFFFFFFFA to 0x50 -> mem_en&mem_we at T+1, mem_addr 0x50, mem_wdata 0xFFFFFFFA, cpu_done T+2, dbg_done stays 0.
- Both ports request continuously from reset -> grant order CPU, dbg, CPU, dbg; each done pulse to correct port only.
- CPU lh at 0x53 -> cpu_done & cpu_err at T+1, rdata 0, mem_en never asserted; sw at 0x52 same.
- reset=0 during CAP of sb -> no mem_we ever, all outputs 0 next cycle; after release, pending dbg request served first only if CPU idle.
